// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: widths, ALU opcodes,
// branch condition codes and the bus driver select encoding.
package datapath_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 512;
    localparam int REG_COUNT = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

    localparam logic [1:0] C2_ZERO = 2'b00;
    localparam logic [1:0] C2_NZ   = 2'b01;
    localparam logic [1:0] C2_GE   = 2'b10;
    localparam logic [1:0] C2_LT   = 2'b11;

    typedef enum logic [3:0] {
        BUS_NONE   = 4'd0,
        BUS_REG    = 4'd1,
        BUS_BA     = 4'd2,
        BUS_PC     = 4'd3,
        BUS_MDR    = 4'd4,
        BUS_ZHI    = 4'd5,
        BUS_ZLO    = 4'd6,
        BUS_HI     = 4'd7,
        BUS_LO     = 4'd8,
        BUS_INPORT = 4'd9,
        BUS_C      = 4'd10,
        BUS_Y      = 4'd11
    } bus_sel_e;

    function automatic logic con_test(input logic [1:0] c2, input logic [DATA_W-1:0] v);
        logic r;
        case (c2)
            C2_ZERO: r = (v == '0);
            C2_NZ:   r = (v != '0);
            C2_GE:   r = ~v[DATA_W-1];
            default: r = v[DATA_W-1];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; produces a 64-bit
// result whose upper word is only meaningful for mul and div.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [4:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cin,
    input  logic                inc_pc,
    output logic [2*DATA_W-1:0] c
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] b_div;
    logic        [2*DATA_W-1:0] a_dup;
    logic        [DATA_W-1:0]   quo;
    logic        [DATA_W-1:0]   rem;
    logic        [DATA_W-1:0]   ror_w;
    logic        [DATA_W-1:0]   rol_w;
    logic        [DATA_W-1:0]   cin_w;
    logic        [DATA_W-1:0]   one_w;

    always_comb begin
        a_ext = {{DATA_W{a[DATA_W-1]}}, a};
        b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        // Divide in the 64-bit domain so MIN / -1 cannot overflow; a zero
        // divisor is swapped for 1 and the result is discarded below.
        b_div = (b == '0) ? 64'sd1 : b_ext;
        quo   = DATA_W'(a_ext / b_div);
        rem   = DATA_W'(a_ext % b_div);
        a_dup = {a, a};
        ror_w = DATA_W'(a_dup >> b[4:0]);
        rol_w = DATA_W'((a_dup << b[4:0]) >> DATA_W);
        cin_w = {{(DATA_W-1){1'b0}}, cin};
        one_w = {{(DATA_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        c = '0;
        if (inc_pc) begin
            c[DATA_W-1:0] = b + one_w;
        end else begin
            case (op)
                OP_SUB:          c[DATA_W-1:0] = a - b - cin_w;
                OP_AND, OP_ANDI: c[DATA_W-1:0] = a & b;
                OP_OR,  OP_ORI:  c[DATA_W-1:0] = a | b;
                OP_SHR:          c[DATA_W-1:0] = a >> b[4:0];
                OP_SHL:          c[DATA_W-1:0] = a << b[4:0];
                OP_ROR:          c[DATA_W-1:0] = ror_w;
                OP_ROL:          c[DATA_W-1:0] = rol_w;
                OP_NEG:          c[DATA_W-1:0] = -b;
                OP_NOT:          c[DATA_W-1:0] = ~b;
                OP_MUL:          c = a_ext * b_ext;
                OP_DIV:          c = (b == '0) ? '0 : {rem, quo};
                default:         c[DATA_W-1:0] = a + b + cin_w;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: architectural registers, register file,
// bus mux, CON logic and RAM, sequenced cycle by cycle by external controls.
module datapath
    import datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
    output logic [DATA_W-1:0] OutPort_output,
    input  logic              IncPC,
    input  logic              CONin,
    input  logic              RAM_write,
    input  logic              MDR_enable,
    input  logic              MDRout,
    input  logic              MAR_enable,
    input  logic              IR_enable,
    input  logic              MDR_read,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              HI_enable,
    input  logic              LO_enable,
    input  logic              ZHighIn,
    input  logic              ZLowIn,
    input  logic              Y_enable,
    input  logic              PC_enable,
    input  logic              OutPort_enable,
    input  logic              InPortout,
    input  logic              PCout,
    input  logic              Yout,
    input  logic              ZLowout,
    input  logic              ZHighout,
    input  logic              LOout,
    input  logic              HIout,
    input  logic              Cout,
    input  logic              BAout,
    input  logic [DATA_W-1:0] InPort_input,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              R_in,
    input  logic              R_out,
    input  logic              Cin,
    input  logic              branch_flag
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [AW-1:0]       mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic [DATA_W-1:0]   in_port_q, in_port_d;
    logic [DATA_W-1:0]   out_port_q, out_port_d;
    logic                con_q, con_d;
    logic [DATA_W-1:0]   regs_q [REG_COUNT];
    logic [DATA_W-1:0]   regs_d [REG_COUNT];

    logic [DATA_W-1:0]   ram [MEM_DEPTH];
    logic [DATA_W-1:0]   ram_rd;

    logic [DATA_W-1:0]   bus;
    bus_sel_e            bus_sel;
    logic [3:0]          sel_idx;
    logic [REG_COUNT-1:0] sel_onehot;
    logic [2*DATA_W-1:0] alu_c;

    // Register select: OR of the enabled IR fields, decoded one-hot for writes.
    always_comb begin
        sel_idx    = ({4{Gra}} & ir_q[26:23])
                   | ({4{Grb}} & ir_q[22:19])
                   | ({4{Grc}} & ir_q[18:15]);
        sel_onehot = REG_COUNT'(1) << sel_idx;
    end

    always_comb begin
        if      (R_out)     bus_sel = BUS_REG;
        else if (BAout)     bus_sel = BUS_BA;
        else if (PCout)     bus_sel = BUS_PC;
        else if (MDRout)    bus_sel = BUS_MDR;
        else if (ZHighout)  bus_sel = BUS_ZHI;
        else if (ZLowout)   bus_sel = BUS_ZLO;
        else if (HIout)     bus_sel = BUS_HI;
        else if (LOout)     bus_sel = BUS_LO;
        else if (InPortout) bus_sel = BUS_INPORT;
        else if (Cout)      bus_sel = BUS_C;
        else if (Yout)      bus_sel = BUS_Y;
        else                bus_sel = BUS_NONE;
    end

    always_comb begin
        case (bus_sel)
            BUS_REG:    bus = regs_q[sel_idx];
            BUS_BA:     bus = (sel_idx == 4'd0) ? '0 : regs_q[sel_idx];
            BUS_PC:     bus = pc_q;
            BUS_MDR:    bus = mdr_q;
            BUS_ZHI:    bus = z_q[2*DATA_W-1:DATA_W];
            BUS_ZLO:    bus = z_q[DATA_W-1:0];
            BUS_HI:     bus = hi_q;
            BUS_LO:     bus = lo_q;
            BUS_INPORT: bus = in_port_q;
            BUS_C:      bus = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};
            BUS_Y:      bus = y_q;
            default:    bus = '0;
        endcase
    end

    datapath_alu u_alu (
        .op     (ir_q[31:27]),
        .a      (y_q),
        .b      (bus),
        .cin    (Cin),
        .inc_pc (IncPC),
        .c      (alu_c)
    );

    assign ram_rd = ram[mar_q];

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        y_d        = y_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        z_d        = z_q;
        con_d      = con_q;
        in_port_d  = InPort_input;
        out_port_d = out_port_q;
        regs_d     = regs_q;

        // A branch only commits the bus into PC when the last CON test passed.
        if (PC_enable && (!branch_flag || con_q)) pc_d = bus;
        if (IR_enable)      ir_d  = bus;
        if (MAR_enable)     mar_d = bus[AW-1:0];
        if (MDR_enable)     mdr_d = MDR_read ? ram_rd : Mdatain;
        if (Y_enable)       y_d   = bus;
        if (HI_enable)      hi_d  = bus;
        if (LO_enable)      lo_d  = bus;
        if (ZLowIn)         z_d[DATA_W-1:0]        = alu_c[DATA_W-1:0];
        if (ZHighIn)        z_d[2*DATA_W-1:DATA_W] = alu_c[2*DATA_W-1:DATA_W];
        if (CONin)          con_d = con_test(ir_q[20:19], bus);
        if (OutPort_enable) out_port_d = bus;

        for (int i = 0; i < REG_COUNT; i++) begin
            if (R_in && sel_onehot[i]) regs_d[i] = bus;
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pc_q       <= '0;
            ir_q       <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            y_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            z_q        <= '0;
            con_q      <= 1'b0;
            in_port_q  <= '0;
            out_port_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            y_q        <= y_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            z_q        <= z_d;
            con_q      <= con_d;
            in_port_q  <= in_port_d;
            out_port_q <= out_port_d;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
        end
    end

    // RAM keeps its contents through Clear; a same-cycle MDR load is not yet visible here.
    always_ff @(posedge Clock) begin
        if (RAM_write) ram[mar_q] <= mdr_q;
    end

    assign OutPort_output = out_port_q;

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized checks of the single-bus datapath against an
// arithmetic reference model of the ALU, CON test and bus behaviour.
module tb_datapath;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] OutPort_output;
    logic        IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
    logic        Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable;
    logic        InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout, BAout;
    logic [31:0] InPort_input = 32'd0;
    logic [31:0] Mdatain = 32'd0;
    logic        R_in, R_out, Cin, branch_flag;

    int checks = 0;
    int errors = 0;

    logic [4:0] ops [17] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                             5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110,
                             5'b01111, 5'b10000, 5'b10001, 5'b00000, 5'b10011};

    datapath dut (
        .Clock(Clock), .Clear(Clear), .OutPort_output(OutPort_output),
        .IncPC(IncPC), .CONin(CONin), .RAM_write(RAM_write), .MDR_enable(MDR_enable),
        .MDRout(MDRout), .MAR_enable(MAR_enable), .IR_enable(IR_enable), .MDR_read(MDR_read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Y_enable(Y_enable), .PC_enable(PC_enable),
        .OutPort_enable(OutPort_enable), .InPortout(InPortout), .PCout(PCout), .Yout(Yout),
        .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout), .Cout(Cout),
        .BAout(BAout), .InPort_input(InPort_input), .Mdatain(Mdatain), .R_in(R_in),
        .R_out(R_out), .Cin(Cin), .branch_flag(branch_flag)
    );

    always #5 Clock = ~Clock;

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin, input logic inc);
        logic [31:0] r;
        longint sa, sb, q, rm;
        int n;
        if (inc) return {32'd0, b + 32'd1};
        n  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'b00100:          r = a - b - 32'(cin);
            5'b00101, 5'b01100: r = a & b;
            5'b00110, 5'b01101: r = a | b;
            5'b00111:          r = a >> n;
            5'b01000:          r = a << n;
            5'b01001:          r = (a >> n) | (a << (32 - n));
            5'b01010:          r = (a << n) | (a >> (32 - n));
            5'b10000:          r = -b;
            5'b10001:          r = ~b;
            5'b01110:          return 64'(sa * sb);
            5'b01111: begin
                if (b == 32'd0) return 64'd0;
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            default:           r = a + b + 32'(cin);
        endcase
        return {32'd0, r};
    endfunction

    function automatic logic ref_con(input logic [1:0] c2, input logic [31:0] v);
        case (c2)
            2'd0:    return v == 32'd0;
            2'd1:    return v != 32'd0;
            2'd2:    return $signed(v) >= 0;
            default: return $signed(v) < 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read} = '0;
        {Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable} = '0;
        {InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout, BAout} = '0;
        {R_in, R_out, Cin, branch_flag} = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic inport(input logic [31:0] v);
        idle();
        InPort_input = v;
        tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        idle();
        Mdatain = v; MDR_enable = 1'b1;
        tick();
        idle();
        MDRout = 1'b1; IR_enable = 1'b1;
        tick();
        idle();
    endtask

    task automatic write_reg_ga(input logic [31:0] v);
        inport(v);
        InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        tick();
        idle();
    endtask

    // Caller raises the bus driver(s) first; the bus value lands in OutPort_output.
    task automatic peek(input string tag, input logic [31:0] exp);
        OutPort_enable = 1'b1;
        tick();
        idle();
        check(tag, {32'd0, OutPort_output}, {32'd0, exp});
    endtask

    task automatic run_alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic inc);
        load_ir({op, 27'd0});
        inport(a);
        InPortout = 1'b1; Y_enable = 1'b1;
        tick();
        inport(b);
        InPortout = 1'b1; Cin = cin; IncPC = inc; ZLowIn = 1'b1; ZHighIn = 1'b1;
        tick();
        idle();
        check(tag, dut.z_q, ref_alu(op, a, b, cin, inc));
    endtask

    initial begin
        idle();
        Clear = 1'b1;
        #2;
        check("rst_pc", {32'd0, dut.pc_q}, 64'd0);
        check("rst_ir", {32'd0, dut.ir_q}, 64'd0);
        check("rst_out", {32'd0, OutPort_output}, 64'd0);
        #10 Clear = 1'b0;

        // Fetch: MAR <= PC, Z <= PC + 1, then PC <= Z.
        tick();
        PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
        tick();
        idle();
        check("fetch_mar", {55'd0, dut.mar_q}, 64'd0);
        check("fetch_z", dut.z_q, 64'd1);
        ZLowout = 1'b1; PC_enable = 1'b1;
        tick();
        idle();
        check("fetch_pc", {32'd0, dut.pc_q}, 64'd1);

        load_ir(32'h9980_0000);
        check("ir_load", {32'd0, dut.ir_q}, 64'h9980_0000);

        write_reg_ga(32'h20);
        check("r3_load", {32'd0, dut.regs_q[3]}, 64'h20);
        Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1;
        tick();
        idle();
        check("jr_pc", {32'd0, dut.pc_q}, 64'h20);

        // brzr R2: taken when R2 == 0, not taken when R2 == 5.
        load_ir(32'h9100_0000);
        write_reg_ga(32'd0);
        Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
        tick();
        check("brzr_con1", {63'd0, dut.con_q}, 64'd1);
        inport(32'h40);
        InPortout = 1'b1; PC_enable = 1'b1; branch_flag = 1'b1;
        tick();
        check("brzr_taken", {32'd0, dut.pc_q}, 64'h40);
        write_reg_ga(32'd5);
        Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
        tick();
        check("brzr_con0", {63'd0, dut.con_q}, 64'd0);
        inport(32'h80);
        InPortout = 1'b1; PC_enable = 1'b1; branch_flag = 1'b1;
        tick();
        check("brzr_not_taken", {32'd0, dut.pc_q}, 64'h40);
        inport(32'h80);
        InPortout = 1'b1; PC_enable = 1'b1;
        tick();
        check("pc_unconditional", {32'd0, dut.pc_q}, 64'h80);

        // Bus priority and the idle bus.
        idle();
        PCout = 1'b1; InPortout = 1'b1; Yout = 1'b1;
        peek("prio_pc_over_in", 32'h80);
        Gra = 1'b1; R_out = 1'b1; PCout = 1'b1; MDRout = 1'b1;
        peek("prio_reg_over_pc", 32'd5);
        peek("bus_idle", 32'd0);

        for (int i = 0; i < 10; i++) begin
            logic [1:0]  c2;
            logic [31:0] v;
            int          k;
            c2 = 2'($urandom_range(0, 3));
            k  = int'($urandom_range(0, 3));
            v  = (k == 0) ? 32'd0 : (k == 1) ? 32'h8000_0000 : $urandom;
            load_ir({5'b10010, 4'd0, 2'b00, c2, 19'd0});
            inport(v);
            InPortout = 1'b1; CONin = 1'b1;
            tick();
            idle();
            check($sformatf("con_c2_%0d", c2), {63'd0, dut.con_q}, {63'd0, ref_con(c2, v)});
        end

        // R0 is a real register through R_out but reads as zero through BAout.
        load_ir(32'd0);
        write_reg_ga(32'hDEAD_BEEF);
        R_out = 1'b1;
        peek("r0_rout", 32'hDEAD_BEEF);
        BAout = 1'b1;
        peek("r0_baout", 32'd0);

        load_ir(32'h0004_0001);
        Cout = 1'b1;
        peek("cout_neg", 32'hFFFC_0001);
        load_ir(32'h0003_FFFF);
        Cout = 1'b1;
        peek("cout_pos", 32'h0003_FFFF);

        run_alu("mul_6_m3", 5'b01110, 32'd6, 32'hFFFF_FFFD, 1'b0, 1'b0);
        check("mul_z", dut.z_q, 64'hFFFF_FFFF_FFFF_FFEE);
        ZHighout = 1'b1; HI_enable = 1'b1;
        tick();
        idle();
        ZLowout = 1'b1; LO_enable = 1'b1;
        tick();
        idle();
        HIout = 1'b1;
        peek("hi_word", 32'hFFFF_FFFF);
        LOout = 1'b1;
        peek("lo_word", 32'hFFFF_FFEE);
        run_alu("div_7_2", 5'b01111, 32'd7, 32'd2, 1'b0, 1'b0);
        check("div_z", dut.z_q, 64'h0000_0001_0000_0003);
        run_alu("div_m7_2", 5'b01111, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_alu("div_by_0", 5'b01111, 32'd123, 32'd0, 1'b0, 1'b0);
        run_alu("incpc_over_mul", 5'b01110, 32'd9, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_alu("sub_cin", 5'b00100, 32'd10, 32'd3, 1'b1, 1'b0);
        run_alu("rol_31", 5'b01010, 32'h8000_0001, 32'd31, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            op = ops[$urandom_range(0, 16)];
            run_alu($sformatf("alu_op_%b", op), op, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        ZLowout = 1'b1;
        peek("zlow_bus", dut.z_q[31:0]);

        // RAM: a write in the same cycle as an MDR load stores the old MDR.
        inport(32'd5);
        InPortout = 1'b1; MAR_enable = 1'b1;
        tick();
        idle();
        check("mar_5", {55'd0, dut.mar_q}, 64'd5);
        Mdatain = 32'h1111; MDR_enable = 1'b1;
        tick();
        idle();
        Mdatain = 32'h2222; MDR_enable = 1'b1; RAM_write = 1'b1;
        tick();
        idle();
        check("mdr_new", {32'd0, dut.mdr_q}, 64'h2222);
        MDR_read = 1'b1; MDR_enable = 1'b1;
        tick();
        idle();
        check("ram_old_mdr", {32'd0, dut.mdr_q}, 64'h1111);

        // Clear in the middle of a cycle, with a sequence step in flight.
        PCout = 1'b1;
        peek("pre_clear_out", 32'h80);
        PCout = 1'b1; Y_enable = 1'b1; ZLowIn = 1'b1;
        #3 Clear = 1'b1;
        #1;
        check("clr_pc", {32'd0, dut.pc_q}, 64'd0);
        check("clr_ir", {32'd0, dut.ir_q}, 64'd0);
        check("clr_z", dut.z_q, 64'd0);
        check("clr_con", {63'd0, dut.con_q}, 64'd0);
        check("clr_out", {32'd0, OutPort_output}, 64'd0);
        for (int r = 0; r < 16; r++) check($sformatf("clr_r%0d", r), {32'd0, dut.regs_q[r]}, 64'd0);
        #1 Clear = 1'b0;
        idle();

        inport(32'd5);
        InPortout = 1'b1; MAR_enable = 1'b1;
        tick();
        idle();
        MDR_read = 1'b1; MDR_enable = 1'b1;
        tick();
        idle();
        check("ram_survives_clear", {32'd0, dut.mdr_q}, 64'h1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
